// File: rtl/ber_ctrl_pkg.sv
// Shared types and constants for the BER run controller and its probability table.
package ber_ctrl_pkg;

    localparam int          TBL_DEPTH_DEFAULT = 64;
    localparam int          TBL_AW            = 6;
    localparam logic [31:0] IDX_IDLE          = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_DRAIN,
        ST_LATCH
    } run_state_t;

endpackage

// File: rtl/prob_tbl_ram.sv
// Noise probability table: one write port, one registered read port.
module prob_tbl_ram
    import ber_ctrl_pkg::*;
#(
    parameter int DEPTH = TBL_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [TBL_AW-1:0] wr_addr,
    input  logic [63:0]       wr_data,
    input  logic              rd_en,
    input  logic [TBL_AW-1:0] rd_addr,
    output logic [63:0]       rd_data
);

    logic [63:0] mem [DEPTH];

    // Contents are deliberately not reset so the host table survives rst.
    always_ff @(posedge clk) begin
        if (we && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ber_run_ctrl.sv
// BER measurement run sequencer: loads the probability table into the datapath,
// runs it until a stop condition or abort, drains, then latches the counters.
//
// state  | meaning
// IDLE   | waiting for start; dut_rstn holds so results stay readable
// LOAD   | stream table[0..TBL_DEPTH-1] to the datapath, datapath held in reset
// SETTLE | one idle-index cycle before enabling the datapath
// RUN    | datapath enabled, cycle counter running, stop conditions checked
// DRAIN  | datapath disabled for DRAIN_CYCLES so in-flight frames complete
// LATCH  | copy counters to res_*, pulse done
module ber_run_ctrl
    import ber_ctrl_pkg::*;
#(
    parameter int TBL_DEPTH    = TBL_DEPTH_DEFAULT,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tbl_we,
    input  logic [5:0]  tbl_addr,
    input  logic [63:0] tbl_data,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  n_interleave_cfg,
    input  logic [63:0] target_frames,
    input  logic [63:0] target_frame_errors,
    input  logic [63:0] max_cycles,
    input  logic [63:0] total_bits,
    input  logic [63:0] total_bit_errors_pre,
    input  logic [63:0] total_bit_errors_post,
    input  logic [63:0] total_frames,
    input  logic [63:0] total_frame_errors,
    output logic        dut_en,
    output logic        dut_rstn,
    output logic [31:0] probability_idx,
    output logic [63:0] probability_in,
    output logic [3:0]  n_interleave,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic        timed_out,
    output logic [63:0] res_bits,
    output logic [63:0] res_err_pre,
    output logic [63:0] res_err_post,
    output logic [63:0] res_frames,
    output logic [63:0] res_frame_errs
);

    localparam logic [31:0] LAST_IDX   = 32'(TBL_DEPTH - 1);
    localparam logic [31:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 32'(DRAIN_CYCLES - 1) : 32'd0;

    run_state_t        state;
    logic [63:0]       cyc_cnt;
    logic [63:0]       cyc_inc;
    logic [31:0]       drain_cnt;
    logic              hit_frames;
    logic              hit_ferr;
    logic              hit_cyc;
    logic              stop_run;
    logic              tbl_rd_en;
    logic [TBL_AW-1:0] tbl_rd_addr;

    // The RAM read is issued one cycle ahead of the index so data and index align.
    always_comb begin
        cyc_inc     = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 64'd1;
        hit_frames  = (target_frames != '0) && (total_frames >= target_frames);
        hit_ferr    = (target_frame_errors != '0) && (total_frame_errors >= target_frame_errors);
        hit_cyc     = (max_cycles != '0) && (cyc_inc >= max_cycles);
        stop_run    = hit_frames || hit_ferr || hit_cyc;
        tbl_rd_en   = 1'b0;
        tbl_rd_addr = '0;
        if (state == ST_IDLE && start) begin
            tbl_rd_en = 1'b1;
        end else if (state == ST_LOAD && probability_idx != LAST_IDX) begin
            tbl_rd_en   = 1'b1;
            tbl_rd_addr = TBL_AW'(probability_idx + 32'd1);
        end
    end

    prob_tbl_ram #(
        .DEPTH (TBL_DEPTH)
    ) u_tbl (
        .clk     (clk),
        .rst     (rst),
        .we      (tbl_we && !busy),
        .wr_addr (tbl_addr),
        .wr_data (tbl_data),
        .rd_en   (tbl_rd_en),
        .rd_addr (tbl_rd_addr),
        .rd_data (probability_in)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            dut_en          <= 1'b0;
            dut_rstn        <= 1'b0;
            probability_idx <= IDX_IDLE;
            n_interleave    <= 4'd1;
            busy            <= 1'b0;
            done            <= 1'b0;
            aborted         <= 1'b0;
            timed_out       <= 1'b0;
            cyc_cnt         <= '0;
            drain_cnt       <= '0;
            res_bits        <= '0;
            res_err_pre     <= '0;
            res_err_post    <= '0;
            res_frames      <= '0;
            res_frame_errs  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_interleave    <= n_interleave_cfg;
                        cyc_cnt         <= '0;
                        aborted         <= 1'b0;
                        timed_out       <= 1'b0;
                        dut_rstn        <= 1'b0;
                        probability_idx <= '0;
                        busy            <= 1'b1;
                        state           <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        aborted         <= 1'b1;
                        busy            <= 1'b0;
                        probability_idx <= IDX_IDLE;
                        state           <= ST_IDLE;
                    end else if (probability_idx == LAST_IDX) begin
                        probability_idx <= IDX_IDLE;
                        state           <= ST_SETTLE;
                    end else begin
                        probability_idx <= probability_idx + 32'd1;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        dut_en   <= 1'b1;
                        dut_rstn <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cyc_cnt <= cyc_inc;
                    if (stop_run || abort) begin
                        dut_en    <= 1'b0;
                        aborted   <= abort;
                        timed_out <= hit_cyc;
                        drain_cnt <= DRAIN_LOAD;
                        state     <= (DRAIN_CYCLES == 0) ? ST_LATCH : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= ST_LATCH;
                    end else begin
                        drain_cnt <= drain_cnt - 32'd1;
                    end
                end
                ST_LATCH: begin
                    res_bits       <= total_bits;
                    res_err_pre    <= total_bit_errors_pre;
                    res_err_post   <= total_bit_errors_post;
                    res_frames     <= total_frames;
                    res_frame_errs <= total_frame_errors;
                    done           <= 1'b1;
                    busy           <= 1'b0;
                    state          <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ber_run_ctrl.sv
// Directed bench for ber_run_ctrl with a frame-counting datapath model.
module tb_ber_run_ctrl;

    localparam int DRAIN = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        tbl_we;
    logic [5:0]  tbl_addr;
    logic [63:0] tbl_data;
    logic        start;
    logic        abort;
    logic [3:0]  n_interleave_cfg;
    logic [63:0] target_frames;
    logic [63:0] target_frame_errors;
    logic [63:0] max_cycles;
    logic [63:0] total_bits;
    logic [63:0] total_bit_errors_pre;
    logic [63:0] total_bit_errors_post;
    logic [63:0] total_frames;
    logic [63:0] total_frame_errors;
    logic        dut_en;
    logic        dut_rstn;
    logic [31:0] probability_idx;
    logic [63:0] probability_in;
    logic [3:0]  n_interleave;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        timed_out;
    logic [63:0] res_bits;
    logic [63:0] res_err_pre;
    logic [63:0] res_err_post;
    logic [63:0] res_frames;
    logic [63:0] res_frame_errs;

    int n_vec = 0;
    int n_err = 0;

    ber_run_ctrl #(
        .TBL_DEPTH    (64),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .tbl_we                (tbl_we),
        .tbl_addr              (tbl_addr),
        .tbl_data              (tbl_data),
        .start                 (start),
        .abort                 (abort),
        .n_interleave_cfg      (n_interleave_cfg),
        .target_frames         (target_frames),
        .target_frame_errors   (target_frame_errors),
        .max_cycles            (max_cycles),
        .total_bits            (total_bits),
        .total_bit_errors_pre  (total_bit_errors_pre),
        .total_bit_errors_post (total_bit_errors_post),
        .total_frames          (total_frames),
        .total_frame_errors    (total_frame_errors),
        .dut_en                (dut_en),
        .dut_rstn              (dut_rstn),
        .probability_idx       (probability_idx),
        .probability_in        (probability_in),
        .n_interleave          (n_interleave),
        .busy                  (busy),
        .done                  (done),
        .aborted               (aborted),
        .timed_out             (timed_out),
        .res_bits              (res_bits),
        .res_err_pre           (res_err_pre),
        .res_err_post          (res_err_post),
        .res_frames            (res_frames),
        .res_frame_errs        (res_frame_errs)
    );

    always #5 clk = ~clk;

    // Datapath model: one frame per enabled cycle, cleared while held in reset.
    logic [63:0] frames = '0;
    always @(posedge clk) begin
        if (!dut_rstn) frames <= '0;
        else if (dut_en) frames <= frames + 64'd1;
    end
    assign total_frames          = frames;
    assign total_bits            = frames << 3;
    assign total_bit_errors_pre  = frames >> 1;
    assign total_bit_errors_post = frames >> 2;
    assign total_frame_errors    = frames >> 3;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the first DRAIN cycle with the number of RUN cycles seen.
    task automatic run_phase(output int run_cyc);
        int guard;
        guard   = 0;
        run_cyc = 0;
        while (!dut_en && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        while (dut_en && run_cyc < 5000) begin
            @(negedge clk);
            run_cyc++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_en();
        int guard;
        guard = 0;
        while (!dut_en && guard < 200) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_en"},     64'(dut_en), 64'd0);
        chk({pfx, "_rstn"},   64'(dut_rstn), 64'd0);
        chk({pfx, "_idx"},    64'(probability_idx), 64'hFFFF_FFFF);
        chk({pfx, "_pin"},    probability_in, 64'd0);
        chk({pfx, "_nint"},   64'(n_interleave), 64'd1);
        chk({pfx, "_busy"},   64'(busy), 64'd0);
        chk({pfx, "_done"},   64'(done), 64'd0);
        chk({pfx, "_abrt"},   64'(aborted), 64'd0);
        chk({pfx, "_tout"},   64'(timed_out), 64'd0);
        chk({pfx, "_rbits"},  res_bits, 64'd0);
        chk({pfx, "_rpre"},   res_err_pre, 64'd0);
        chk({pfx, "_rpost"},  res_err_post, 64'd0);
        chk({pfx, "_rfrm"},   res_frames, 64'd0);
        chk({pfx, "_rferr"},  res_frame_errs, 64'd0);
    endtask

    initial begin
        int rc;
        int n;
        int seen;

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tbl_we = 1'b0;
        tbl_addr = '0;
        tbl_data = '0;
        n_interleave_cfg = 4'd0;
        target_frames = '0;
        target_frame_errors = '0;
        max_cycles = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        rst = 1'b0;

        for (int i = 0; i < 64; i++) begin
            tbl_we   = 1'b1;
            tbl_addr = 6'(i);
            tbl_data = 64'(i * 3);
            @(negedge clk);
        end
        tbl_we = 1'b0;

        // Table streaming then a frame-target run.
        n_interleave_cfg = 4'd5;
        target_frames    = 64'd100;
        pulse_start();
        chk("load_rstn", 64'(dut_rstn), 64'd0);
        for (int i = 0; i < 64; i++) begin
            chk("load_idx", 64'(probability_idx), 64'(i));
            chk("load_pin", probability_in, 64'(i * 3));
            @(negedge clk);
        end
        chk("settle_idx", 64'(probability_idx), 64'hFFFF_FFFF);
        chk("settle_en", 64'(dut_en), 64'd0);
        chk("settle_rstn", 64'(dut_rstn), 64'd0);
        @(negedge clk);
        chk("run_en", 64'(dut_en), 64'd1);
        chk("run_rstn", 64'(dut_rstn), 64'd1);
        chk("run_nint", 64'(n_interleave), 64'd5);
        run_phase(rc);
        chk("frm_run_cyc", 64'(rc), 64'd101);
        chk("frm_at_drain", frames, 64'd101);
        wait_done(n);
        chk("frm_done_lat", 64'(n), 64'(DRAIN + 1));
        chk("frm_res_frames", res_frames, 64'd101);
        chk("frm_res_bits", res_bits, 64'd808);
        chk("frm_res_pre", res_err_pre, 64'd50);
        chk("frm_res_post", res_err_post, 64'd25);
        chk("frm_res_ferr", res_frame_errs, 64'd12);
        chk("frm_busy", 64'(busy), 64'd0);
        chk("frm_tout", 64'(timed_out), 64'd0);
        chk("frm_abrt", 64'(aborted), 64'd0);
        @(negedge clk);
        chk("frm_done_pulse", 64'(done), 64'd0);
        chk("idle_rstn_hold", 64'(dut_rstn), 64'd1);

        // Cycle limit.
        target_frames = '0;
        max_cycles    = 64'd50;
        pulse_start();
        run_phase(rc);
        chk("cyc_run_cyc", 64'(rc), 64'd50);
        wait_done(n);
        chk("cyc_done_lat", 64'(n), 64'(DRAIN + 1));
        chk("cyc_tout", 64'(timed_out), 64'd1);
        chk("cyc_abrt", 64'(aborted), 64'd0);
        chk("cyc_res_frames", res_frames, 64'd50);

        // Abort during LOAD, then reload and abort coinciding with the cycle limit.
        max_cycles = '0;
        pulse_start();
        repeat (10) @(negedge clk);
        chk("ab_ld_idx", 64'(probability_idx), 64'd10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_ld_busy", 64'(busy), 64'd0);
        chk("ab_ld_abrt", 64'(aborted), 64'd1);
        chk("ab_ld_tout", 64'(timed_out), 64'd0);
        chk("ab_ld_idx_idle", 64'(probability_idx), 64'hFFFF_FFFF);
        chk("ab_ld_rstn", 64'(dut_rstn), 64'd0);
        seen = 0;
        repeat (20) begin
            if (done) seen++;
            @(negedge clk);
        end
        chk("ab_ld_no_done", 64'(seen), 64'd0);
        max_cycles = 64'd5;
        pulse_start();
        chk("reload_idx0", 64'(probability_idx), 64'd0);
        chk("reload_pin0", probability_in, 64'd0);
        @(negedge clk);
        chk("reload_idx1", 64'(probability_idx), 64'd1);
        chk("reload_pin1", probability_in, 64'd3);
        wait_en();
        repeat (4) @(negedge clk);
        chk("ab_run_en5", 64'(dut_en), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_run_drain", 64'(dut_en), 64'd0);
        wait_done(n);
        chk("ab_run_done_lat", 64'(n), 64'(DRAIN + 1));
        chk("ab_run_abrt", 64'(aborted), 64'd1);
        chk("ab_run_tout", 64'(timed_out), 64'd1);
        chk("ab_run_frames", res_frames, 64'd5);

        // start and table write during RUN are ignored.
        max_cycles = 64'd20;
        pulse_start();
        wait_en();
        repeat (2) @(negedge clk);
        start    = 1'b1;
        tbl_we   = 1'b1;
        tbl_addr = 6'd0;
        tbl_data = 64'hDEAD;
        @(negedge clk);
        start  = 1'b0;
        tbl_we = 1'b0;
        run_phase(rc);
        chk("busy_run_rest", 64'(rc), 64'd17);
        wait_done(n);
        chk("busy_done_lat", 64'(n), 64'(DRAIN + 1));
        repeat (5) @(negedge clk);
        chk("busy_no_restart", 64'(busy), 64'd0);

        // Unlimited run, then reset mid-run.
        max_cycles = '0;
        pulse_start();
        chk("busy_tbl_kept", probability_in, 64'd0);
        wait_en();
        repeat (300) @(negedge clk);
        chk("unlim_en", 64'(dut_en), 64'd1);
        chk("unlim_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("mid");
        tbl_we   = 1'b1;
        tbl_addr = 6'd0;
        tbl_data = 64'd77;
        @(negedge clk);
        tbl_we = 1'b0;
        pulse_start();
        chk("post_rst_wr", probability_in, 64'd77);
        @(negedge clk);
        chk("post_rst_tbl1", probability_in, 64'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("post_rst_abort", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
